// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_STABLE_TICKS = 16;
  localparam int DEF_SYNC_STAGES  = 2;

  // Counter width for a modulus of n; a counter is always at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stability counter, level and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int   SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic RST_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // One extra bit so the counter can represent STABLE_TICKS-1 for any STABLE_TICKS >= 1.
  localparam int             CW   = $clog2(STABLE_TICKS) + 1;
  localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_channel: SYNC_STAGES must be >= 2");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("debounce_channel: STABLE_TICKS must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // Plain shift chain into the clock domain; nothing sits between the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  // Accept a new level after STABLE_TICKS consecutive mismatching ticks; pulses last one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      q    <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (sync == q) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt  <= '0;
          q    <= sync;
          rise <= sync;
          fall <= ~sync;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: shared sample-tick prescaler feeding independent channels.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS     = 10,
  parameter int                  TICK_DIV     = DEF_TICK_DIV,
  parameter int                  STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int                  SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic [CHANNELS-1:0] RESET_VAL    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int            PW    = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("debounce_multi: TICK_DIV must be >= 1");
  end
  if (CHANNELS < 1) begin : g_bad_ch
    $error("debounce_multi: CHANNELS must be >= 1");
  end

  logic [PW-1:0] pcnt;
  logic          tick;

  // With TICK_DIV=1 the counter is stuck at 0 and tick is permanently high.
  assign tick = (pcnt == PLAST);

  // Free-running prescaler 0..TICK_DIV-1, restarted by reset so the tick phase is known.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES),
      .RST_BIT      (RESET_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .d    (din[i]),
      .q    (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: history-based reference model, pulse scoreboard, directed + random stimulus.
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int ST   = 4;
  localparam int SS   = 2;
  localparam int MAXE = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] din = 4'hF;

  logic [N-1:0] dout1, rise1, fall1;
  logic         changed1;
  logic [N-1:0] dout5, rise5, fall5;
  logic         changed5;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS(N), .TICK_DIV(1), .STABLE_TICKS(ST), .SYNC_STAGES(SS), .RESET_VAL(4'h0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .dout(dout1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  debounce_multi #(
    .CHANNELS(N), .TICK_DIV(5), .STABLE_TICKS(ST), .SYNC_STAGES(SS), .RESET_VAL(4'h0)
  ) u_dut5 (
    .clk(clk), .rst(rst), .din(din), .dout(dout5), .rise(rise5), .fall(fall5), .changed(changed5)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the full input/reset history per edge; at each sample tick a channel flips
  // when its last ST sampled values (all after the last reset/flip) disagree with the output.
  typedef struct {
    int           e;
    logic [N-1:0] r;
    logic [N-1:0] f;
  } ev_t;

  logic [N-1:0] din_h [MAXE];
  bit           rst_h [MAXE];
  int           e_cnt = -1;
  int           last_rst [2] = '{0, 0};
  int           last_upd [2][N];
  logic [N-1:0] m_dout [2] = '{4'h0, 4'h0};
  ev_t          q0[$];
  ev_t          q1[$];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < N; c++) last_upd[i][c] = -1;
  end

  function automatic int td_of(input int i);
    return (i == 0) ? 1 : 5;
  endfunction

  // Value the debouncer sees at edge u: din captured SS edges earlier, unless a reset intervened.
  function automatic logic sync_at(input int u, input int c);
    for (int j = u - SS; j <= u - 1; j++)
      if (j < 0 || rst_h[j]) return 1'b0;
    return din_h[u - SS][c];
  endfunction

  function automatic bit is_tick(input int i, input int t);
    return (t > last_rst[i]) && (((t - last_rst[i]) % td_of(i)) == 0);
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] r, f;
    int           floor_e, u;
    bit           ok;
    ev_t          ev;
    e_cnt++;
    if (e_cnt >= MAXE) begin
      $display("FAIL model_history_overflow: got %0d expected below %0d", e_cnt, MAXE);
      $fatal(1, "history overflow");
    end
    din_h[e_cnt] = din;
    rst_h[e_cnt] = rst;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_dout[i]   = '0;
        last_rst[i] = e_cnt;
      end else if (is_tick(i, e_cnt)) begin
        r = '0;
        f = '0;
        for (int c = 0; c < N; c++) begin
          floor_e = (last_upd[i][c] > last_rst[i]) ? last_upd[i][c] : last_rst[i];
          ok = 1'b1;
          u  = e_cnt;
          for (int k = 0; k < ST; k++) begin
            if (u <= floor_e || sync_at(u, c) == m_dout[i][c]) ok = 1'b0;
            u -= td_of(i);
          end
          if (ok) begin
            if (m_dout[i][c]) f[c] = 1'b1;
            else              r[c] = 1'b1;
            m_dout[i][c]   = ~m_dout[i][c];
            last_upd[i][c] = e_cnt;
          end
        end
        if ((r | f) != '0) begin
          ev.e = e_cnt;
          ev.r = r;
          ev.f = f;
          if (i == 0) q0.push_back(ev);
          else        q1.push_back(ev);
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  function automatic bit q_has(input int i);
    return (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
  endfunction

  function automatic ev_t q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_pop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mon(input int i, input logic [N-1:0] d, input logic [N-1:0] r,
                     input logic [N-1:0] f, input logic ch);
    ev_t ev;
    bit  due;
    while (q_has(i)) begin
      ev = q_front(i);
      if (ev.e >= e_cnt) break;
      q_pop(i);
      checks++;
      errs++;
      $display("FAIL i%0d_missed_pulse: edge %0d got none expected rise=%h fall=%h", i, ev.e, ev.r, ev.f);
    end
    due = 1'b0;
    if (q_has(i)) begin
      ev  = q_front(i);
      due = (ev.e == e_cnt);
    end
    if (ch) begin
      if (due) begin
        q_pop(i);
        chk($sformatf("i%0d_rise", i), 32'(r), 32'(ev.r));
        chk($sformatf("i%0d_fall", i), 32'(f), 32'(ev.f));
      end else begin
        checks++;
        errs++;
        $display("FAIL i%0d_unexpected_pulse: edge %0d got rise=%h fall=%h expected none", i, e_cnt, r, f);
      end
    end else if (due) begin
      q_pop(i);
      checks++;
      errs++;
      $display("FAIL i%0d_missing_pulse: edge %0d got changed=0 expected rise=%h fall=%h", i, e_cnt, ev.r, ev.f);
    end
    chk($sformatf("i%0d_dout", i), 32'(d), 32'(m_dout[i]));
  endtask

  int last_tick_e = -1;

  always @(negedge clk) begin
    if (e_cnt >= 0) begin
      mon(0, dout1, rise1, fall1, changed1);
      mon(1, dout5, rise5, fall5, changed5);
      if (rst_h[e_cnt]) last_tick_e = -1;
      if (u_dut5.tick) begin
        if (last_tick_e >= 0) chk("tick5_period", 32'(e_cnt - last_tick_e), 32'd5);
        last_tick_e = e_cnt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          n, rises, falls;
    bit          found;
    logic [5:0]  pat;
    int          mode, den;

    // 1: reset with all inputs high, then release
    rst = 1'b1;
    din = 4'hF;
    repeat (3) cyc();
    chk("t1_dout_in_reset", 32'(dout1), 32'h0);
    chk("t1_pulses_in_reset", 32'(rise1 | fall1), 32'h0);
    rst = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      cyc();
      n++;
      if (dout1 == 4'hF) found = 1'b1;
    end
    chk("t1_release_latency", 32'(n), 32'd6);
    chk("t1_rise", 32'(rise1), 32'hF);
    chk("t1_changed", 32'(changed1), 32'h1);
    cyc();
    chk("t1_changed_next", 32'(changed1), 32'h0);

    // 2: glitchy rising pattern on channel 0
    din = 4'h0;
    repeat (12) cyc();
    pat = 6'b011011;
    rises = 0;
    falls = 0;
    for (int k = 0; k < 20; k++) begin
      din[0] = (k < 6) ? pat[k] : 1'b1;
      cyc();
      rises += int'(rise1[0]);
      falls += int'(fall1[0]);
      if (k == 10) chk("t2_dout_before", 32'(dout1[0]), 32'h0);
      if (k == 11) chk("t2_dout_after", 32'(dout1[0]), 32'h1);
    end
    chk("t2_rise_count", 32'(rises), 32'd1);
    chk("t2_fall_count", 32'(falls), 32'd0);

    // 3: falling edge on channel 0
    din[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 4) chk("t3_dout_before", 32'(dout1[0]), 32'h1);
      if (k == 5) begin
        chk("t3_dout_after", 32'(dout1[0]), 32'h0);
        chk("t3_fall", 32'(fall1), 32'h1);
        chk("t3_rise", 32'(rise1), 32'h0);
      end
    end

    // 4: TICK_DIV=5 instance latency
    din = 4'h0;
    repeat (40) cyc();
    din[1] = 1'b1;
    n = 0;
    found = 1'b0;
    while (n < 60 && !found) begin
      cyc();
      n++;
      if (dout5[1]) found = 1'b1;
    end
    chk("t4_latency_in_range", 32'(n >= 17 && n <= 22), 32'h1);
    chk("t4_rise5", 32'(rise5), 32'h2);

    // 5: reset mid-count
    din = 4'h0;
    repeat (40) cyc();
    din[2] = 1'b1;
    rises = 0;
    repeat (5) begin
      cyc();
      rises += int'(rise1[2]);
    end
    rst = 1'b1;
    cyc();
    chk("t5_dout_after_reset", 32'(dout1), 32'h0);
    chk("t5_no_rise", 32'(rises + int'(rise1[2])), 32'd0);
    rst = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      cyc();
      n++;
      if (dout1[2]) found = 1'b1;
    end
    chk("t5_restart_latency", 32'(n), 32'd6);

    // 6: simultaneous rise and fall
    din = 4'h2;
    repeat (40) cyc();
    din = 4'h1;
    n = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      cyc();
      n++;
      if (changed1) found = 1'b1;
    end
    chk("t6_latency", 32'(n), 32'd6);
    chk("t6_rise", 32'(rise1), 32'h1);
    chk("t6_fall", 32'(fall1), 32'h2);
    cyc();
    chk("t6_idle_next", 32'({changed1, rise1, fall1}), 32'h0);

    // random phase: slow, fast and mixed toggling with rare resets
    for (int seg = 0; seg < 15; seg++) begin
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 200; k++) begin
        for (int c = 0; c < N; c++) begin
          if (mode == 0)      den = 16;
          else if (mode == 1) den = 2;
          else                den = (c < 2) ? 3 : 12;
          if (mode == 1 && c == 3) din[c] = ~din[c];
          else if ($urandom_range(0, den - 1) == 0) din[c] = ~din[c];
        end
        rst = ($urandom_range(0, 399) == 0);
        cyc();
      end
    end
    rst = 1'b0;
    repeat (60) cyc();
    chk("drain_q1", 32'(q0.size()), 32'd0);
    chk("drain_q5", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
